fadd_seq_ctrl: RTL and testbench
================================

// Module: fadd_seq_ctrl
// PURPOSE
//  Sequencer that performs WIDTH-bit add/subtract by streaming nibbles through one shared
//  4-bit registered CLA adder (fadd), LSB nibble first, chaining the adder's carry-out back
//  into carry-in. Sits between a valid/ready requester and the fadd instance; owns fadd's
//  inputs and its sync reset.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4, >= 8; NIB = WIDTH/4 (derived)
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      controller can accept (combinational: state==IDLE)
//  req_a        in   WIDTH  operand A
//  req_b        in   WIDTH  operand B
//  req_cin      in   1      carry-in for add; ignored when req_sub=1
//  req_sub      in   1      1: A - B (B inverted, carry-in forced 1)
//  rsp_valid    out  1      result present; held until rsp_ready
//  rsp_ready    in   1      consumer accepts result
//  rsp_sum      out  WIDTH  result
//  rsp_cout     out  1      final carry-out (for sub: 1 = no borrow)
//  rsp_ovf      out  1      signed overflow (fa_ovf of top nibble)
//  fa_a, fa_b   out  4      nibble operands to fadd
//  fa_cin       out  1      carry-in to fadd
//  fa_rst       out  1      fadd sync active-high reset
//  fa_sum       in   4      fadd registered sum (valid 1 clk after inputs)
//  fa_cout      in   1      fadd registered carry-out
//  fa_ovf       in   1      fadd overflow (c4^c3 of last registered nibble)
// BEHAVIOUR
//  - Async reset: state=IDLE, idx=0, op regs=0, rsp_valid=0, rsp_sum=0, rsp_cout=0,
//    rsp_ovf=0; req_ready=1 (IDLE); fa_* outputs per IDLE below.
//  - States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  - IDLE: req_ready=1; fa_rst=1, fa_a=fa_b=0, fa_cin=0. On req_valid: latch a,
//    b' = req_sub ? ~req_b : req_b, c0 = req_sub ? 1 : req_cin; idx=0; go ISSUE.
//  - ISSUE (NIB cycles, idx 0..NIB-1): fa_rst=0, fa_a=a[4idx+:4], fa_b=b'[4idx+:4];
//    fa_cin = (idx==0) ? c0 : fa_cout. For idx>=1 capture fa_sum into sum[4(idx-1)+:4]
//    at cycle end. idx==NIB-1 -> DRAIN, else idx++.
//  - DRAIN (1 cycle): fa_rst=0, fa_a=fa_b=0, fa_cin=0; capture fa_sum into top nibble,
//    fa_cout->rsp_cout, fa_ovf->rsp_ovf; go DONE with rsp_valid=1.
//  - DONE: rsp_* held stable, req_ready=0, fa_rst=1; on rsp_ready: rsp_valid=0, go IDLE.
//    rsp_sum/cout/ovf retain last value after handshake until next DRAIN.
//  - Latency: rsp_valid rises NIB+1 clocks after the accepting edge (5 for WIDTH=16).
//    Throughput: one op per NIB+3 clocks with rsp_ready tied high.
//  - req_valid ignored outside IDLE; no request dropped or double-accepted.
//  - Full-width carry ripples one nibble/clock; carry from all-ones operands must chain
//    through every nibble.
//  - Reset mid-operation: immediate abort to IDLE, partial result discarded, rsp_valid=0;
//    fa_rst=1 during reset, so fadd is cleared on the next clk.
//  - Op registers update only on accept; requester may change req_* after handshake.
// TESTING (WIDTH=16, rsp_ready=1 unless stated)
//  1 add 0x1234+0x0FFF cin=0 -> rsp_sum=0x2233, cout=0, ovf=0; rsp_valid 5 clks after accept
//  2 add 0xFFFF+0x0001 cin=0 -> rsp_sum=0x0000, cout=1, ovf=0 (carry ripples 4 nibbles)
//  3 add 0x7FFF+0x0001 cin=0 -> rsp_sum=0x8000, cout=0, ovf=1
//  4 sub 0x0005-0x0007 (req_cin=0) -> rsp_sum=0xFFFE, cout=0, ovf=0; fa_cin=1 on idx 0
//  5 rsp_ready low 10 clks in DONE with req_valid high -> rsp_* stable, req_ready=0,
//    no accept; rsp_ready high -> IDLE, next req accepted on following edge
//  6 rst_n low during ISSUE idx=2 -> rsp_valid=0, req_ready=1 immediately; after release
//    0x0001+0x0001 -> rsp_sum=0x0002, no residue from aborted op

Source files
------------

// File: rtl/fadd_seq_ctrl.sv
// Multi-nibble add/subtract sequencer driving one shared 4-bit registered adder.
// Operands stream LSB nibble first; the adder's registered carry feeds the next nibble.
module fadd_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    input  logic             req_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic [3:0]       fa_a,
    output logic [3:0]       fa_b,
    output logic             fa_cin,
    output logic             fa_rst,
    input  logic [3:0]       fa_sum,
    input  logic             fa_cout,
    input  logic             fa_ovf
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c0;
    logic [WIDTH-5:0] acc;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_c0     <= 1'b0;
            acc       <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_a  <= req_a;
                        op_b  <= req_sub ? ~req_b : req_b;
                        op_c0 <= req_sub | req_cin;
                        idx   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The adder output seen now belongs to the nibble issued last cycle.
                    for (int n = 0; n < NIB - 1; n++) begin
                        if (idx == IDX_W'(n + 1)) begin
                            acc[4*n +: 4] <= fa_sum;
                        end
                    end
                    if (idx == IDX_W'(NIB - 1)) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    rsp_sum   <= {fa_sum, acc};
                    rsp_cout  <= fa_cout;
                    rsp_ovf   <= fa_ovf;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx == IDX_W'(n)) begin
                nib_a = op_a[4*n +: 4];
                nib_b = op_b[4*n +: 4];
            end
        end
    end

    // The adder is held in reset whenever no nibble is in flight, so every op starts clean.
    always_comb begin
        fa_rst = 1'b1;
        fa_a   = '0;
        fa_b   = '0;
        fa_cin = 1'b0;
        case (state)
            ISSUE: begin
                fa_rst = 1'b0;
                fa_a   = nib_a;
                fa_b   = nib_b;
                fa_cin = (idx == '0) ? op_c0 : fa_cout;
            end
            DRAIN: fa_rst = 1'b0;
            default: fa_rst = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_fadd_seq_ctrl.sv
// Bench for fadd_seq_ctrl: includes a behavioural 4-bit registered adder and a
// full-width arithmetic reference for add/sub results, carry and signed overflow.
module tb_fadd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic        req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_ovf;
    logic [3:0]  fa_a;
    logic [3:0]  fa_b;
    logic        fa_cin;
    logic        fa_rst;
    logic [3:0]  fa_sum;
    logic        fa_cout;
    logic        fa_ovf;

    int errors = 0;
    int checks = 0;

    fadd_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_rst(fa_rst),
        .fa_sum(fa_sum), .fa_cout(fa_cout), .fa_ovf(fa_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural registered 4-bit adder with sync active-high reset
    logic [4:0] fa_full;
    logic [3:0] fa_low3;
    always_comb begin
        fa_full = {1'b0, fa_a} + {1'b0, fa_b} + {4'b0, fa_cin};
        fa_low3 = {1'b0, fa_a[2:0]} + {1'b0, fa_b[2:0]} + {3'b0, fa_cin};
    end
    always @(posedge clk) begin
        if (fa_rst) begin
            fa_sum  <= 4'h0;
            fa_cout <= 1'b0;
            fa_ovf  <= 1'b0;
        end else begin
            fa_sum  <= fa_full[3:0];
            fa_cout <= fa_full[4];
            fa_ovf  <= fa_full[4] ^ fa_low3[3];
        end
    end

    // Reference: {ovf, cout, sum[15:0]}
    function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
        logic [15:0] bp;
        logic [16:0] full;
        logic        ovf;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {16'b0, (sub ? 1'b1 : cin)};
        ovf  = (a[15] == bp[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge right after the accepting edge; returns with the response up.
    task automatic wait_rsp(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub, input string tag);
        logic [17:0] exp;
        int k;
        exp = ref_op(a, b, cin, sub);
        check({tag, ".fa_rst_idx0"}, 32'(fa_rst), 32'(0));
        check({tag, ".fa_cin_idx0"}, 32'(fa_cin), 32'(sub | cin));
        check({tag, ".fa_a_idx0"}, 32'(fa_a), 32'(a[3:0]));
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".latency"}, 32'(k), 32'(5));
        check({tag, ".sum"}, 32'(rsp_sum), 32'(exp[15:0]));
        check({tag, ".cout"}, 32'(rsp_cout), 32'(exp[16]));
        check({tag, ".ovf"}, 32'(rsp_ovf), 32'(exp[17]));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input string tag);
        logic [15:0] held;
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".req_ready"}, 32'(req_ready), 32'(1));
        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 16'($urandom);
        req_cin = 1'($urandom); req_sub = 1'($urandom);
        wait_rsp(a, b, cin, sub, tag);
        if (rsp_ready) begin
            held = rsp_sum;
            @(negedge clk);
            check({tag, ".vld_clear"}, 32'(rsp_valid), 32'(0));
            check({tag, ".sum_held"}, 32'(rsp_sum), 32'(held));
        end
    endtask

    initial begin
        logic [15:0] saved;
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_cin = 1'b0; req_sub = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'(1));
        check("rst.rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst.rsp_sum", 32'(rsp_sum), 32'(0));
        check("rst.fa_rst", 32'(fa_rst), 32'(1));
        check("rst.fa_a", 32'({fa_a, fa_b, 3'b0, fa_cin}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "t1");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "t2");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "t3");
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "t4");
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, "t4b");

        // Response back-pressure with a competing request pending
        rsp_ready = 1'b0;
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, "t5");
        saved = rsp_sum;
        req_a = 16'h0001; req_b = 16'h0002; req_cin = 1'b0; req_sub = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5.hold_vld", 32'(rsp_valid), 32'(1));
            check("t5.hold_sum", 32'(rsp_sum), 32'(saved));
            check("t5.hold_rdy", 32'(req_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5.release_vld", 32'(rsp_valid), 32'(0));
        check("t5.release_rdy", 32'(req_ready), 32'(1));
        @(negedge clk);
        check("t5.accepted", 32'(req_ready), 32'(0));
        req_valid = 1'b0;
        wait_rsp(16'h0001, 16'h0002, 1'b0, 1'b0, "t5n");
        @(negedge clk);

        // Abort mid-operation at nibble index 2
        req_a = 16'hABCD; req_b = 16'h1111; req_cin = 1'b1; req_sub = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6.rsp_valid", 32'(rsp_valid), 32'(0));
        check("t6.req_ready", 32'(req_ready), 32'(1));
        check("t6.fa_rst", 32'(fa_rst), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "t6n");

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin
                ra = 16'hFFFF; rb = 16'hFFFF;
            end
            run_op(ra, rb, 1'($urandom), 1'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
